// File: rtl/alu_accumulator_if.sv
// alu_accumulator_if
//   Handshake and data bundle between the switch/key front end and the
//   accumulating ALU.
//   Signals:
//     start  request to execute op (driven by master)
//     op     3-bit operation select (driven by master)
//     a      WIDTH-bit operand A (driven by master)
//     acc    2*WIDTH-bit accumulator/result (driven by slave)
//     busy   multiply in progress (driven by slave)
//     done   one-cycle pulse after acc takes a new result (driven by slave)
//     zero   acc == 0 flag (driven by slave)
//   Modports: master = requester side, slave = ALU side.
interface alu_accumulator_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     a;
  logic [2*WIDTH-1:0]   acc;
  logic                 busy;
  logic                 done;
  logic                 zero;

  modport master (
    output start, op, a,
    input  acc, busy, done, zero
  );

  modport slave (
    input  start, op, a,
    output acc, busy, done, zero
  );
endinterface

// File: rtl/alu_accumulator.sv
// alu_accumulator
//   Registered accumulating ALU. Operand A comes from the bus, operand B is
//   the low WIDTH bits of the accumulator, so results chain from one
//   operation to the next. Ops 000-110 finish in one edge; op 111 runs a
//   WIDTH-edge shift-add multiply while busy is high.
//   Ports:
//     clk    system clock, rising edge
//     reset  synchronous active-high reset
//     bus    alu_accumulator_if.slave (start/op/a in, acc/busy/done/zero out)
//   Parameter:
//     WIDTH  operand width (>= 2); acc is 2*WIDTH bits
module alu_accumulator #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_accumulator_if.slave     bus
);

  localparam int RW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [RW-1:0] SHIFT_LIMIT = RW'(RW);
  localparam logic [CW-1:0] LAST_STEP   = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t            state_r;
  logic [RW-1:0]     acc_r;
  logic              busy_r;
  logic              done_r;
  logic              zero_r;
  logic [CW-1:0]     cnt_r;
  logic [RW-1:0]     prod_r;
  logic [RW-1:0]     mcand_r;
  logic [WIDTH-1:0]  mplier_r;

  logic [RW-1:0]     result_s;
  logic [RW-1:0]     addend_s;
  logic [RW-1:0]     prod_next_s;

  // Single-edge operations; op 111 is handled by the multiply sequencer.
  function automatic logic [RW-1:0] alu_result(
    input logic [2:0]       op_i,
    input logic [WIDTH-1:0] a_i,
    input logic [WIDTH-1:0] b_i
  );
    logic [RW-1:0] a_ext;
    logic [RW-1:0] b_ext;
    logic [RW-1:0] res;
    a_ext = {{WIDTH{1'b0}}, a_i};
    b_ext = {{WIDTH{1'b0}}, b_i};
    case (op_i)
      3'b000: res = a_ext + {{(RW-1){1'b0}}, 1'b1};
      3'b001: res = a_ext + b_ext;
      3'b010: res = a_ext - b_ext;
      3'b011: res = {a_i | b_i, a_i ^ b_i};
      3'b100: res = {{(RW-1){1'b0}}, (|a_i) | (|b_i)};
      // Shift distances of 2*WIDTH or more clear the whole result.
      3'b101: res = (a_ext >= SHIFT_LIMIT) ? {RW{1'b0}} : (b_ext << a_i);
      3'b110: res = (a_ext >= SHIFT_LIMIT) ? {RW{1'b0}} : (b_ext >> a_i);
      default: res = {RW{1'b0}};
    endcase
    return res;
  endfunction

  // Result of a single-edge op using the current accumulator as operand B.
  always_comb begin
    result_s = alu_result(bus.op, bus.a, acc_r[WIDTH-1:0]);
  end

  // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    addend_s = {RW{1'b0}};
    if (mplier_r[cnt_r]) begin
      addend_s = mcand_r << cnt_r;
    end else begin
      addend_s = {RW{1'b0}};
    end
    prod_next_s = prod_r + addend_s;
  end

  // Control FSM and all architectural registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      acc_r    <= {RW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      zero_r   <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      prod_r   <= {RW{1'b0}};
      mcand_r  <= {RW{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == 3'b111) begin
              // Operands are frozen here; later changes on op/a are ignored.
              state_r  <= MUL;
              busy_r   <= 1'b1;
              cnt_r    <= {CW{1'b0}};
              prod_r   <= {RW{1'b0}};
              mcand_r  <= {{WIDTH{1'b0}}, bus.a};
              mplier_r <= acc_r[WIDTH-1:0];
            end else begin
              acc_r  <= result_s;
              done_r <= 1'b1;
              zero_r <= (result_s == {RW{1'b0}});
            end
          end
        end
        MUL: begin
          prod_r <= prod_next_s;
          cnt_r  <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            acc_r   <= prod_next_s;
            zero_r  <= (prod_next_s == {RW{1'b0}});
            done_r  <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.acc  = acc_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.zero = zero_r;

endmodule
